// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data access engine for the 5-stage MIPS pipeline.
// Runs one load or store per request over a word-wide valid/ack bus with a
// delayed read response. It stalls the pipeline until the access completes.
// It also handles big-endian byte extraction (LB/LBU) and byte insertion (SB).
//
// Build option:
//   MEM_BYTE_RMW_EN - SB is performed as read-modify-write with a full-word
//                     write. Use this for bus memories without byte enables.
//                     When undefined, SB is a single write with a one-hot
//                     bus_be.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_we,
    input  logic              mem_byte,
    input  logic              mem_signextend,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-3:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_rvalid
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_REQ   = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
`ifdef MEM_BYTE_RMW_EN
    localparam logic [2:0] ST_RMW_REQ  = 3'd3;
    localparam logic [2:0] ST_RMW_WAIT = 3'd4;
`endif
    localparam logic [2:0] ST_WR_REQ   = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    logic [2:0]        state_reg,     state_next;
    logic              bus_req_reg,   bus_req_next;
    logic              bus_we_reg,    bus_we_next;
    logic [ADDR_W-3:0] bus_addr_reg,  bus_addr_next;
    logic [31:0]       bus_wdata_reg, bus_wdata_next;
    logic [3:0]        bus_be_reg,    bus_be_next;
    logic [31:0]       load_data_reg, load_data_next;
    logic [1:0]        lane_reg,      lane_next;
    logic              byte_reg,      byte_next;
    logic              sext_reg,      sext_next;
`ifdef MEM_BYTE_RMW_EN
    logic [7:0]        wbyte_reg,     wbyte_next;
    logic [31:0]       merged_word;
`endif

    // Byte lanes of the read word. Lane 0 is the MSB byte (big-endian).
    logic [7:0]  rd_lane [4];
    logic [7:0]  sel_byte;
    logic [31:0] load_word;

    // Store word and byte enables computed from the live request inputs.
    logic [31:0] store_wdata;
    logic [3:0]  store_be;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi]      = bus_rdata[31-8*gi -: 8];
            // Word stores enable every lane; byte stores enable only lane addr[1:0].
            assign store_be[3-gi]   = ~mem_byte | (addr[1:0] == 2'(gi));
`ifdef MEM_BYTE_RMW_EN
            // Replace the addressed lane and keep the other three from the read word.
            assign merged_word[31-8*gi -: 8] = (lane_reg == 2'(gi)) ? wbyte_reg : rd_lane[gi];
`endif
        end
    endgenerate

    assign sel_byte    = rd_lane[lane_reg];
    assign load_word   = byte_reg ? {{24{sext_reg & sel_byte[7]}}, sel_byte} : bus_rdata;
    assign store_wdata = mem_byte ? {4{write_data[7:0]}} : write_data;

    // The pipeline is held until the access reaches DONE. Reset forces this low.
    assign stall = rst_n & req_valid & (state_reg != ST_DONE);

    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_be    = bus_be_reg;
    assign load_data = load_data_reg;

    // Next-state and bus-output logic. Bus fields hold their value unless a new
    // request is launched, so they remain stable while waiting for bus_ack.
    always_comb begin
        state_next     = state_reg;
        bus_req_next   = bus_req_reg;
        bus_we_next    = bus_we_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        bus_be_next    = bus_be_reg;
        load_data_next = load_data_reg;
        lane_next      = lane_reg;
        byte_next      = byte_reg;
        sext_next      = sext_reg;
`ifdef MEM_BYTE_RMW_EN
        wbyte_next     = wbyte_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    lane_next     = addr[1:0];
                    byte_next     = mem_byte;
                    sext_next     = mem_signextend;
                    bus_addr_next = addr[ADDR_W-1:2];
                    if (mem_we) begin
`ifdef MEM_BYTE_RMW_EN
                        if (mem_byte) begin
                            // Fetch the whole word first; the byte is merged on return.
                            wbyte_next   = write_data[7:0];
                            state_next   = ST_RMW_REQ;
                            bus_req_next = 1'b1;
                            bus_we_next  = 1'b0;
                            bus_be_next  = 4'hF;
                        end else begin
                            state_next     = ST_WR_REQ;
                            bus_req_next   = 1'b1;
                            bus_we_next    = 1'b1;
                            bus_wdata_next = store_wdata;
                            bus_be_next    = store_be;
                        end
`else
                        state_next     = ST_WR_REQ;
                        bus_req_next   = 1'b1;
                        bus_we_next    = 1'b1;
                        bus_wdata_next = store_wdata;
                        bus_be_next    = store_be;
`endif
                    end else if (mem_read) begin
                        state_next   = ST_RD_REQ;
                        bus_req_next = 1'b1;
                        bus_we_next  = 1'b0;
                        bus_be_next  = 4'hF;
                    end else begin
                        // A request with no access type completes immediately
                        // so the pipeline cannot be held forever.
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RD_REQ: begin
                if (bus_ack) begin
                    bus_req_next = 1'b0;
                    state_next   = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (bus_rvalid) begin
                    load_data_next = load_word;
                    state_next     = ST_DONE;
                end
            end
`ifdef MEM_BYTE_RMW_EN
            ST_RMW_REQ: begin
                if (bus_ack) begin
                    bus_req_next = 1'b0;
                    state_next   = ST_RMW_WAIT;
                end
            end
            ST_RMW_WAIT: begin
                if (bus_rvalid) begin
                    bus_req_next   = 1'b1;
                    bus_we_next    = 1'b1;
                    bus_wdata_next = merged_word;
                    bus_be_next    = 4'hF;
                    state_next     = ST_WR_REQ;
                end
            end
`endif
            ST_WR_REQ: begin
                if (bus_ack) begin
                    bus_req_next = 1'b0;
                    bus_we_next  = 1'b0;
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next   = ST_IDLE;
                bus_req_next = 1'b0;
                bus_we_next  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_be_reg    <= '0;
            load_data_reg <= '0;
            lane_reg      <= '0;
            byte_reg      <= 1'b0;
            sext_reg      <= 1'b0;
`ifdef MEM_BYTE_RMW_EN
            wbyte_reg     <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            bus_req_reg   <= bus_req_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            bus_be_reg    <= bus_be_next;
            load_data_reg <= load_data_next;
            lane_reg      <= lane_next;
            byte_reg      <= byte_next;
            sext_reg      <= sext_next;
`ifdef MEM_BYTE_RMW_EN
            wbyte_reg     <= wbyte_next;
`endif
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access engine for the 5-stage MIPS pipeline. It consumes the memory-control signals produced in decode and carried through EX/MEM (`mem_read`, `mem_we`, `mem_byte`, `mem_signextend`, address, write data). It executes each load or store against a word-wide data-memory bus with a valid/ack request and a delayed read response, and stalls the pipeline until the access completes. It also performs big-endian byte-lane extraction, sign/zero extension for LB/LBU, and byte insertion for SB.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width. The bus word address is `ADDR_W-2` bits.

Ports:
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: the MEM-stage instruction performs a memory access.
- `mem_read` in 1: load.
- `mem_we` in 1: store. Wins if `mem_read` is also high.
- `mem_byte` in 1: byte access (LB/LBU/SB); otherwise word access.
- `mem_signextend` in 1: sign-extend byte loads; zero-extend when low.
- `addr` in ADDR_W: byte address (ALU result).
- `write_data` in 32: store data (rt). SB uses `[7:0]`.
- `stall` out 1: freeze the pipeline while an access is incomplete.
- `load_data` out 32: extended load result. Valid while `state==DONE`.
- `bus_req` out 1: request valid (registered).
- `bus_we` out 1: write request (registered).
- `bus_addr` out ADDR_W-2: word address `addr[ADDR_W-1:2]` (registered).
- `bus_wdata` out 32: write word (registered).
- `bus_be` out 4: byte enables, `[3]`=byte 0 (MSB lane) (registered).
- `bus_ack` in 1: the request is accepted in any cycle where `bus_req & bus_ack`.
- `bus_rdata` in 32: read word.
- `bus_rvalid` in 1: `bus_rdata` valid. Arrives at least 1 cycle after read acceptance.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, RMW_REQ, RMW_WAIT, WR_REQ, DONE.
- IDLE, with `req_valid`: latch `addr`, `write_data`, `mem_byte`, `mem_signextend`.
  - Load: go to RD_REQ.
  - Store: go to WR_REQ, or RMW_REQ when the Configuration macro is set and the store is a byte store.
- RD_REQ / RMW_REQ: `bus_req=1`, `bus_we=0`, `bus_be=4'hF`. Hold until `bus_ack`, then go to RD_WAIT / RMW_WAIT.
- RD_WAIT: on `bus_rvalid`, capture the word and go to DONE.
- RMW_WAIT: on `bus_rvalid`, merge the byte into the captured word and go to WR_REQ.
- WR_REQ: `bus_req=1`, `bus_we=1`. Hold until `bus_ack`, then go to DONE.
- DONE: one cycle. Return to IDLE.
- `stall = rst_n & req_valid & (state != DONE)`. This is the only combinational output. The pipeline advances at the end of DONE, so each request is served exactly once.
- Byte lane is `k = addr[1:0]`, big-endian: lane 0 is `[31:24]` and lane 3 is `[7:0]`.
- Word loads and stores ignore `addr[1:0]`. No misalignment trap.
- LB/LBU: `load_data = sext/zext(rword[31-8k -: 8])`.
- SB without RMW: `bus_wdata = {4{write_data[7:0]}}`, `bus_be` = one-hot with lane k set (`4'b1000 >> k`).
- SW: `bus_wdata = write_data`, `bus_be = 4'hF`.
- `bus_rvalid` is ignored outside RD_WAIT/RMW_WAIT. This covers late responses after a reset.
- Any state with `rst_n==0`: next state IDLE.
- Reset values: `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_wdata=0`, `bus_be=0`, `load_data=0`. `stall=0` while `rst_n` is low.

## Timing
Latencies below assume `bus_ack` is high on the first request cycle and `bus_rvalid` arrives on the first permitted cycle.
- Load: request seen in cycle 0 (IDLE). `bus_req` is high in cycle 1. RD_WAIT is cycle 2, with `rvalid`. DONE is cycle 3. That is 3 stall cycles.
- Store: IDLE is cycle 0, WR_REQ is cycle 1, DONE is cycle 2. That is 2 stall cycles.
- RMW byte store: IDLE, RMW_REQ, RMW_WAIT, WR_REQ, DONE. That is 4 stall cycles.
- Each cycle `bus_ack` is low adds one stall cycle. Each cycle of extra `rvalid` delay adds one stall cycle.
- Bus outputs stay stable while `bus_req & ~bus_ack`.
- Back-to-back accesses: a new request is seen in the cycle after DONE. That gives one dead IDLE cycle between accesses.

## Configuration
- `MEM_BYTE_RMW_EN` defined: SB is done by read-modify-write.
  - The word is read, then byte k is replaced.
  - The write is issued with `bus_be=4'hF`.
  - For bus memories without byte enables.
- `MEM_BYTE_RMW_EN` undefined: SB is a single write with a one-hot `bus_be`. RMW_REQ and RMW_WAIT are unreachable and may be omitted.

## Test plan
- LW at `addr=0x100`, `bus_rdata=0xDEADBEEF`, immediate ack, rvalid in cycle 2:
  - `bus_addr=0x40`, `bus_be=4'hF`, `stall` high in cycles 0–2.
  - `load_data=0xDEADBEEF` in cycle 3.
- LB at `addr=0x101`, word `0x12F45678`, `mem_signextend=1`: `load_data=0xFFFFFFF4`. The same access as LBU gives `0x000000F4`.
- SB `write_data=0x000000AB` at `addr=0x203`:
  - Without macro: `bus_we=1`, `bus_be=4'b0001`, `bus_wdata=0xABABABAB`, 2 stall cycles.
  - With macro and read word `0x11223344`: write `0x112233AB` with `bus_be=4'hF`, 4 stall cycles.
- SW with `bus_ack` held low 3 cycles:
  - `bus_req`, `bus_addr` and `bus_wdata` stay stable.
  - `stall` lasts 5 cycles, then a single DONE cycle.
- Reset mid-load: `rst_n=0` in RD_WAIT. Next cycle is IDLE with `bus_req=0` and `stall=0`. A subsequent stray `bus_rvalid` does not change `load_data`.
- Back-to-back LW then SW: each is issued exactly once on the bus, with one IDLE cycle between DONE and the next request.
